alu_pipe: RTL and testbench

- Parametrised, pipelined successor to the team's combinational 24-bit datapath ALU, used by the matrix-multiplication processor datapath.
- Accepts one operation per cycle over a valid/ready handshake and returns the result 2 cycles later with zero and overflow flags.
- Adds an internal multiply-accumulate register (MAC / CLRACC) so dot products are computed without round-tripping through the register file.
- Supports output backpressure without losing or duplicating operations.

---
 rtl/alu_pipe.sv | 156 +++++++++++++++
 tb/tb_alu_pipe.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Pipelined datapath ALU with valid/ready handshake and an internal
// multiply-accumulate register. S1 holds the accepted operation, S2 holds
// the computed result; out_valid is the S2 occupancy flag.
module alu_pipe #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned SHIFT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c_out,
    output logic             z_out,
    output logic             ovf_out,
    output logic [WIDTH-1:0] acc_out
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned EW = WIDTH + 1;

    localparam logic [2:0] OP_ADD    = 3'd0;
    localparam logic [2:0] OP_MUL    = 3'd1;
    localparam logic [2:0] OP_SUB    = 3'd2;
    localparam logic [2:0] OP_SFTR   = 3'd3;
    localparam logic [2:0] OP_SFTL   = 3'd4;
    localparam logic [2:0] OP_MAC    = 3'd5;
    localparam logic [2:0] OP_CLRACC = 3'd6;
    localparam logic [2:0] OP_PASSA  = 3'd7;

    logic             s1_valid;
    logic [2:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    logic             s2_adv;
    logic             in_xfer;

    logic [PW-1:0]    prod;
    logic [PW-1:0]    shl_ext;
    logic [EW-1:0]    add_sum;
    logic [EW-1:0]    sub_diff;
    logic [EW-1:0]    mac_sum;

    logic [WIDTH-1:0] c_nxt;
    logic             ovf_nxt;
    logic             acc_wr;
    logic [WIDTH-1:0] acc_nxt;

    // Handshake: S2 drains or refills whenever its slot frees up
    always_comb begin
        s2_adv   = s1_valid && (!out_valid || out_ready);
        in_ready = !s1_valid || s2_adv;
        in_xfer  = in_valid && in_ready;
    end

    // S2 datapath: result, overflow and accumulator update for the op in S1
    always_comb begin
        prod     = PW'(s1_a) * PW'(s1_b);
        shl_ext  = PW'(s1_a) << SHIFT;
        add_sum  = EW'(s1_a) + EW'(s1_b);
        sub_diff = EW'(s1_a) - EW'(s1_b);
        mac_sum  = EW'(acc_out) + EW'(prod[WIDTH-1:0]);

        c_nxt   = '0;
        ovf_nxt = 1'b0;
        acc_wr  = 1'b0;
        acc_nxt = acc_out;

        case (s1_op)
            OP_ADD: begin
                c_nxt   = add_sum[WIDTH-1:0];
                ovf_nxt = add_sum[WIDTH];
            end
            OP_MUL: begin
                c_nxt   = prod[WIDTH-1:0];
                ovf_nxt = |prod[PW-1:WIDTH];
            end
            OP_SUB: begin
                c_nxt   = sub_diff[WIDTH-1:0];
                ovf_nxt = sub_diff[WIDTH];
            end
            OP_SFTR: begin
                c_nxt = s1_a >> SHIFT;
            end
            OP_SFTL: begin
                c_nxt   = shl_ext[WIDTH-1:0];
                ovf_nxt = |shl_ext[PW-1:WIDTH];
            end
            OP_MAC: begin
                c_nxt   = mac_sum[WIDTH-1:0];
                ovf_nxt = (|prod[PW-1:WIDTH]) | mac_sum[WIDTH];
                acc_wr  = 1'b1;
                acc_nxt = mac_sum[WIDTH-1:0];
            end
            OP_CLRACC: begin
                acc_wr  = 1'b1;
                acc_nxt = '0;
            end
            OP_PASSA: begin
                c_nxt = s1_a;
            end
            default: begin
                c_nxt = '0;
            end
        endcase
    end

    // S1: capture a new op, or empty out when it moves into S2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (in_xfer) begin
            s1_valid <= 1'b1;
            s1_op    <= op;
            s1_a     <= a_in;
            s1_b     <= b_in;
        end else if (s2_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // S2: load a fresh result, or empty out once the consumer takes it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            c_out     <= '0;
            z_out     <= 1'b0;
            ovf_out   <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= 1'b1;
            c_out     <= c_nxt;
            z_out     <= (c_nxt == '0);
            ovf_out   <= ovf_nxt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Accumulator: written only on the edge its MAC/CLRACC enters S2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_out <= '0;
        end else if (s2_adv && acc_wr) begin
            acc_out <= acc_nxt;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed scenarios plus randomized
// traffic, compared every cycle against an in-order result queue.
module tb_alu_pipe;

    localparam longint unsigned MASK = 64'hFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [23:0] a_in;
    logic [23:0] b_in;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] c_out;
    logic        z_out;
    logic        ovf_out;
    logic [23:0] acc_out;

    alu_pipe #(.WIDTH(24), .SHIFT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c_out     (c_out),
        .z_out     (z_out),
        .ovf_out   (ovf_out),
        .acc_out   (acc_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] c;
        logic        z;
        logic        ovf;
        logic [23:0] acc;
    } exp_t;

    exp_t        q[$];
    logic [23:0] seen[$];
    logic [23:0] m_acc = '0;
    int          inflight = 0;
    int          vectors = 0;
    int          miscompares = 0;
    bit          rand_done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour in plain 64-bit arithmetic
    function automatic exp_t model(input logic [2:0] mop, input logic [23:0] a,
                                   input logic [23:0] b, input logic [23:0] acc_in);
        longint unsigned la = 64'(a);
        longint unsigned lb = 64'(b);
        longint unsigned r;
        exp_t e;
        e.acc = acc_in;
        e.ovf = 1'b0;
        case (mop)
            3'd0: begin r = la + lb; e.ovf = (r > MASK); end
            3'd1: begin r = la * lb; e.ovf = (r > MASK); end
            3'd2: begin r = la - lb; e.ovf = (la < lb); end
            3'd3: r = la >> 8;
            3'd4: begin r = la << 8; e.ovf = (r > MASK); end
            3'd5: begin
                r = la * lb;
                e.ovf = (r > MASK);
                r = 64'(acc_in) + (r & MASK);
                if (r > MASK) e.ovf = 1'b1;
                e.acc = 24'(r & MASK);
            end
            3'd6: begin r = 0; e.acc = '0; end
            default: r = la;
        endcase
        e.c = 24'(r & MASK);
        e.z = (e.c == 24'd0);
        return e;
    endfunction

    function automatic logic [63:0] pk(input exp_t e);
        return 64'({e.c, e.z, e.ovf});
    endfunction

    // Per-cycle compare against the in-order expectation queue
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            m_acc = '0;
            inflight = 0;
        end else begin
            check("in_ready", 64'(in_ready), 64'(!(inflight == 2 && !out_ready)));
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("result_without_op", 64'(out_valid), 64'(0));
                end else begin
                    e = q[0];
                    check("c_out", 64'(c_out), 64'(e.c));
                    check("z_out", 64'(z_out), 64'(e.z));
                    check("ovf_out", 64'(ovf_out), 64'(e.ovf));
                    check("acc_out", 64'(acc_out), 64'(e.acc));
                    if (out_ready) begin
                        void'(q.pop_front());
                        seen.push_back(c_out);
                        inflight--;
                    end
                end
            end
            if (in_valid && in_ready) begin
                e = model(op, a_in, b_in, m_acc);
                m_acc = e.acc;
                q.push_back(e);
                inflight++;
            end
        end
    end

    // Present one op and hold it until accepted; returns 1ns after the accept edge
    task automatic drive(input logic [2:0] o, input logic [23:0] a, input logic [23:0] b);
        bit acc_now;
        int n = 0;
        in_valid = 1'b1;
        op = o;
        a_in = a;
        b_in = b;
        do begin
            @(negedge clk);
            acc_now = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc_now && n < 100);
        if (!acc_now) check("accept_timeout", 64'(in_ready), 64'(1));
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", 64'(q.size()), 64'(0));
    endtask

    initial begin
        exp_t held;
        logic [23:0] hold_c;
        in_valid = 1'b0;
        out_ready = 1'b1;
        op = '0;
        a_in = '0;
        b_in = '0;

        // Model pins against hand-computed values
        check("pin_add", pk(model(3'd0, 24'h000005, 24'h000003, 24'd0)), 64'({24'h000008, 1'b0, 1'b0}));
        check("pin_add_wrap", pk(model(3'd0, 24'hFFFFFF, 24'h000001, 24'd0)), 64'({24'h000000, 1'b1, 1'b1}));
        check("pin_sub", pk(model(3'd2, 24'h000002, 24'h000003, 24'd0)), 64'({24'hFFFFFF, 1'b0, 1'b1}));
        check("pin_mul", pk(model(3'd1, 24'h001000, 24'h001000, 24'd0)), 64'({24'h000000, 1'b1, 1'b1}));
        check("pin_sftl", pk(model(3'd4, 24'h8000FF, 24'h0, 24'd0)), 64'({24'h00FF00, 1'b0, 1'b1}));
        check("pin_sftr", pk(model(3'd3, 24'h123456, 24'h0, 24'd0)), 64'({24'h001234, 1'b0, 1'b0}));
        held = model(3'd5, 24'd4, 24'd5, 24'd6);
        check("pin_mac", 64'({held.c, held.acc}), 64'({24'd26, 24'd26}));

        // Asynchronous reset, checked before any clock edge
        #3 rst = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_c_out", 64'(c_out), 64'(0));
        check("rst_flags", 64'({z_out, ovf_out}), 64'(0));
        check("rst_acc_out", 64'(acc_out), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'(1));

        // First ADD with latency check
        drive(3'd0, 24'h000005, 24'h000003);
        idle();
        @(negedge clk);
        check("latency_early", 64'(out_valid), 64'(0));
        @(negedge clk);
        check("latency_valid", 64'(out_valid), 64'(1));
        check("first_add", 64'(c_out), 64'(24'h000008));
        @(posedge clk);
        #1;

        // Boundary arithmetic back to back
        drive(3'd0, 24'hFFFFFF, 24'h000001);
        drive(3'd2, 24'h000002, 24'h000003);
        drive(3'd1, 24'h001000, 24'h001000);
        drive(3'd4, 24'h8000FF, 24'h5A5A5A);
        drive(3'd3, 24'h123456, 24'h5A5A5A);
        idle();
        drain();

        // Chained MACs at full rate
        seen.delete();
        drive(3'd6, 24'd0, 24'd0);
        drive(3'd5, 24'd2, 24'd3);
        drive(3'd5, 24'd4, 24'd5);
        drive(3'd5, 24'd1, 24'd7);
        idle();
        drain();
        check("mac_count", 64'(seen.size()), 64'(4));
        if (seen.size() == 4) begin
            check("mac_seq", 64'({seen[1], seen[2], seen[3]}), 64'({24'd6, 24'd26, 24'd33}));
        end
        check("mac_acc", 64'(acc_out), 64'(24'd33));
        drive(3'd0, 24'd1, 24'd1);
        idle();
        drain();
        check("acc_after_add", 64'(acc_out), 64'(24'd33));

        // Backpressure: two ops fill the pipe, the rest wait
        seen.delete();
        out_ready = 1'b0;
        drive(3'd7, 24'h000011, 24'd0);
        drive(3'd7, 24'h000022, 24'd0);
        in_valid = 1'b1;
        op = 3'd7;
        a_in = 24'h000033;
        @(negedge clk);
        check("bp_in_ready", 64'(in_ready), 64'(0));
        hold_c = c_out;
        repeat (3) begin
            @(negedge clk);
            check("bp_c_stable", 64'(c_out), 64'(hold_c));
        end
        fork
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b1;
            end
            begin
                drive(3'd7, 24'h000033, 24'd0);
                drive(3'd7, 24'h000044, 24'd0);
                idle();
            end
        join
        drain();
        check("bp_count", 64'(seen.size()), 64'(4));
        if (seen.size() == 4) begin
            check("bp_order", 64'({seen[0], seen[1]}), 64'({24'h11, 24'h22}));
            check("bp_order2", 64'({seen[2], seen[3]}), 64'({24'h33, 24'h44}));
        end

        // Reset with two ops in flight and a loaded accumulator
        drive(3'd6, 24'd0, 24'd0);
        drive(3'd5, 24'd3, 24'd11);
        idle();
        drain();
        check("pre_rst_acc", 64'(acc_out), 64'(24'd33));
        out_ready = 1'b0;
        drive(3'd7, 24'h000001, 24'd0);
        drive(3'd7, 24'h000002, 24'd0);
        idle();
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_c_out", 64'(c_out), 64'(0));
        check("midrst_acc_out", 64'(acc_out), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        seen.delete();
        drive(3'd0, 24'h000005, 24'h000003);
        idle();
        @(negedge clk);
        check("post_rst_early", 64'(out_valid), 64'(0));
        @(negedge clk);
        check("post_rst_valid", 64'(out_valid), 64'(1));
        check("post_rst_c", 64'(c_out), 64'(24'h000008));
        @(posedge clk);
        #1;
        drain();
        check("post_rst_count", 64'(seen.size()), 64'(1));

        // Randomized traffic with random consumer stalls
        fork
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom % 4) != 0;
                end
            end
            begin
                for (int i = 0; i < 400; i++) begin
                    logic [23:0] ra;
                    logic [23:0] rb;
                    ra = 24'($urandom);
                    rb = 24'($urandom);
                    if ($urandom % 4 == 0) ra = 24'($urandom % 4);
                    if ($urandom % 4 == 0) rb = 24'($urandom % 4);
                    if ($urandom % 5 == 0) begin
                        idle();
                        @(posedge clk);
                        #1;
                    end
                    drive(3'($urandom % 8), ra, rb);
                end
                idle();
                rand_done = 1'b1;
            end
        join
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
